// File: rtl/cpu_boot_ctrl.sv
// CPU boot controller: loads instruction/data memories from a stream,
// releases and runs the CPU for a cycle budget, then dumps data memory.
module cpu_boot_ctrl #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] imem_words,
  input  logic [LEN_W-1:0] dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             cpu_enable,
  output logic             cpu_arst_n,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             busy,
  output logic             done
);

  localparam int MAXD =
    (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
  localparam int IW = $clog2(MAXD + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ilen_q, ilen_d;
  logic [IW-1:0]    dlen_q, dlen_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mdata_q, mdata_d;
  logic             done_q, done_d;

  logic [IW-1:0]    idx_nx;
  logic             ilast;
  logic             dlast;

  assign idx_nx = idx_q + IW'(1);
  assign ilast  = (idx_nx == ilen_q);
  assign dlast  = (idx_nx == dlen_q);

  assign ren_ext = 1'b0;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_data  = mdata_q;

  // State, lengths, index, run counter and dump word register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      ilen_q  <= '0;
      dlen_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ilen_q  <= ilen_d;
      dlen_q  <= dlen_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d     = state_q;
    ilen_d      = ilen_q;
    dlen_d      = dlen_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mdata_d     = mdata_q;
    done_d      = 1'b0;
    s_ready     = 1'b0;
    wen_ext     = 1'b0;
    addr_ext    = '0;
    wdata_ext   = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    addr_ext_2  = '0;
    wdata_ext_2 = '0;
    m_valid     = 1'b0;
    cpu_enable  = 1'b0;
    cpu_arst_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ilen_d = (32'(imem_words) > 32'(IMEM_DEPTH))
                 ? IW'(IMEM_DEPTH) : IW'(imem_words);
          dlen_d = (32'(dmem_words) > 32'(DMEM_DEPTH))
                 ? IW'(DMEM_DEPTH) : IW'(dmem_words);
          cnt_d  = run_cycles;
          idx_d  = '0;
          if (ilen_d != '0)
            state_d = LOAD_I;
          else if (dlen_d != '0)
            state_d = LOAD_D;
          else if (run_cycles != '0)
            state_d = RUN;
          else
            done_d = 1'b1;
        end
      end
      LOAD_I: begin
        s_ready  = 1'b1;
        addr_ext = 64'(idx_q) << 2;
        if (s_valid) begin
          wen_ext   = 1'b1;
          wdata_ext = s_data[31:0];
          if (ilast) begin
            idx_d = '0;
            if (dlen_q != '0)
              state_d = LOAD_D;
            else if (cnt_q != '0)
              state_d = RUN;
            else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_nx;
          end
        end
      end
      LOAD_D: begin
        s_ready    = 1'b1;
        addr_ext_2 = 64'(idx_q) << 3;
        if (s_valid) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = s_data;
          if (dlast) begin
            idx_d   = '0;
            state_d = (cnt_q != '0) ? RUN : DUMP_RD;
          end else begin
            idx_d = idx_nx;
          end
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        cpu_arst_n = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          idx_d = '0;
          if (dlen_q != '0)
            state_d = DUMP_RD;
          else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DUMP_RD: begin
        cpu_arst_n = 1'b1;
        ren_ext_2  = 1'b1;
        addr_ext_2 = 64'(idx_q) << 3;
        state_d    = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        cpu_arst_n = 1'b1;
        mdata_d    = rdata_ext_2;
        state_d    = DUMP_OUT;
      end
      DUMP_OUT: begin
        cpu_arst_n = 1'b1;
        m_valid    = 1'b1;
        if (m_ready) begin
          if (dlast) begin
            idx_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nx;
            state_d = DUMP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition and suppresses completion.
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl with a small data-memory model
// (one-cycle read latency) and edge monitors for strobe counting.
module tb_cpu_boot_ctrl;

  logic        clk;
  logic        arst;
  logic        start;
  logic        abort;
  logic [7:0]  imem_words;
  logic [7:0]  dmem_words;
  logic [15:0] run_cycles;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        cpu_enable;
  logic        cpu_arst_n;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int iw_cnt = 0;
  int dw_cnt = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  int dn_cnt = 0;
  logic [63:0] last_iaddr = '0;
  logic        arstn_seen = 1'b0;
  logic [63:0] dmem [0:127];

  logic [31:0] iwords [0:2];
  logic [63:0] dwords [0:1];
  logic [3:0]  pat;

  cpu_boot_ctrl dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .abort       (abort),
    .imem_words  (imem_words),
    .dmem_words  (dmem_words),
    .run_cycles  (run_cycles),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .cpu_enable  (cpu_enable),
    .cpu_arst_n  (cpu_arst_n),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model and strobe monitors.
  always @(posedge clk) begin
    if (wen_ext) begin
      iw_cnt++;
      last_iaddr = addr_ext;
    end
    if (wen_ext_2) begin
      dw_cnt++;
      dmem[addr_ext_2[9:3]] <= wdata_ext_2;
    end
    if (ren_ext_2) begin
      rd_cnt++;
      rdata_ext_2 <= dmem[addr_ext_2[9:3]];
    end
    if (cpu_enable) en_cnt++;
    if (cpu_arst_n) arstn_seen = 1'b1;
    if (done) dn_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  int e0, d0, w0, r0, k;

  initial begin
    iwords[0] = 32'h13;
    iwords[1] = 32'h93;
    iwords[2] = 32'h113;
    dwords[0] = 64'h1111_2222_3333_4444;
    dwords[1] = 64'h5555_6666_7777_8888;
    pat = 4'b1001;
    for (int i = 0; i < 128; i++) dmem[i] = '0;
    rdata_ext_2 = '0;
    arst = 1'b1;
    start = 0; abort = 0;
    imem_words = 0; dmem_words = 0; run_cycles = 0;
    s_valid = 0; s_data = 0; m_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_sready", 64'(s_ready), 0);
    check("rst_arstn", 64'(cpu_arst_n), 0);
    check("rst_en", 64'(cpu_enable), 0);
    check("rst_done", 64'(done), 0);
    check("rst_mdata", m_data, 0);
    arst = 1'b0;

    // Load 3 instructions, run 5 cycles
    @(negedge clk);
    imem_words = 8'd3; dmem_words = 0; run_cycles = 16'd5;
    start = 1;
    e0 = en_cnt; w0 = iw_cnt; d0 = dn_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 0;
      s_valid = 1;
      s_data = 64'(iwords[i]);
      #1;
      check("A_wen", 64'(wen_ext), 1);
      check("A_addr", addr_ext, 64'(4 * i));
      check("A_wdata", 64'(wdata_ext), 64'(iwords[i]));
      check("A_arstn_load", 64'(cpu_arst_n), 0);
    end
    @(negedge clk);
    s_valid = 0;
    #1;
    check("A_run_en", 64'(cpu_enable), 1);
    check("A_run_arstn", 64'(cpu_arst_n), 1);
    check("A_run_sready", 64'(s_ready), 0);
    wait_done("A_done", 20);
    check("A_idle", 64'(busy), 0);
    check("A_en_cycles", 64'(en_cnt - e0), 5);
    check("A_writes", 64'(iw_cnt - w0), 3);
    check("A_last_addr", last_iaddr, 8);
    check("A_arstn_seen", 64'(arstn_seen), 1);
    @(negedge clk);
    #1;
    check("A_done_pulse", 64'(done), 0);
    check("A_done_cnt", 64'(dn_cnt - d0), 1);
    check("A_arstn_idle", 64'(cpu_arst_n), 0);

    // Stalled data load
    @(negedge clk);
    imem_words = 0; dmem_words = 8'd2; run_cycles = 0;
    start = 1; m_ready = 1;
    w0 = dw_cnt;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 0;
      s_valid = pat[i];
      s_data = pat[i] ? dwords[k] : 64'hDEAD;
      #1;
      check("B_wen", 64'(wen_ext_2), 64'(pat[i]));
      if (pat[i]) begin
        check("B_addr", addr_ext_2, 64'(8 * k));
        check("B_wdata", wdata_ext_2, dwords[k]);
        k++;
      end
    end
    @(negedge clk);
    s_valid = 0;
    wait_done("B_done", 40);
    check("B_writes", 64'(dw_cnt - w0), 2);
    check("B_mem0", dmem[0], dwords[0]);
    check("B_mem1", dmem[1], dwords[1]);

    // Dump with backpressure
    @(negedge clk);
    imem_words = 0; dmem_words = 8'd2; run_cycles = 16'd1;
    start = 1; m_ready = 0;
    r0 = rd_cnt;
    @(negedge clk);
    start = 0; s_valid = 1; s_data = 64'hAA;
    @(negedge clk);
    s_data = 64'hBB;
    @(negedge clk);
    s_valid = 0;
    #1;
    check("C_run", 64'(cpu_enable), 1);
    @(negedge clk);
    #1;
    check("C_ren0", 64'(ren_ext_2), 1);
    check("C_raddr0", addr_ext_2, 0);
    @(negedge clk);
    #1;
    check("C_wait_mvalid", 64'(m_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("C_stall_mvalid", 64'(m_valid), 1);
      check("C_stall_mdata", m_data, 64'hAA);
    end
    @(negedge clk);
    m_ready = 1;
    #1;
    check("C_hs0", m_data, 64'hAA);
    @(negedge clk);
    #1;
    check("C_ren1", 64'(ren_ext_2), 1);
    check("C_raddr1", addr_ext_2, 8);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("C_mvalid1", 64'(m_valid), 1);
    check("C_mdata1", m_data, 64'hBB);
    wait_done("C_done", 5);
    check("C_reads", 64'(rd_cnt - r0), 2);

    // Abort during RUN
    @(negedge clk);
    imem_words = 0; dmem_words = 0; run_cycles = 16'd10;
    start = 1;
    e0 = en_cnt; d0 = dn_cnt;
    @(negedge clk);
    start = 0;
    #1;
    check("D_en1", 64'(cpu_enable), 1);
    @(negedge clk);
    abort = 1;
    #1;
    check("D_en2", 64'(cpu_enable), 1);
    @(negedge clk);
    abort = 0;
    #1;
    check("D_busy", 64'(busy), 0);
    check("D_en", 64'(cpu_enable), 0);
    check("D_arstn", 64'(cpu_arst_n), 0);
    repeat (15) @(negedge clk);
    check("D_en_cycles", 64'(en_cnt - e0), 2);
    check("D_no_done", 64'(dn_cnt - d0), 0);

    // Clamp 200 -> 128 instruction writes
    @(negedge clk);
    imem_words = 8'd200; dmem_words = 0; run_cycles = 0;
    start = 1; s_valid = 1; s_data = 64'h13;
    w0 = iw_cnt;
    @(negedge clk);
    start = 0;
    wait_done("E_done", 300);
    s_valid = 0;
    check("E_writes", 64'(iw_cnt - w0), 128);
    check("E_last_addr", last_iaddr, 508);

    // All-empty start
    @(negedge clk);
    imem_words = 0; dmem_words = 0; run_cycles = 0;
    start = 1;
    w0 = iw_cnt + dw_cnt; r0 = rd_cnt;
    @(negedge clk);
    start = 0;
    #1;
    check("E0_done", 64'(done), 1);
    check("E0_busy", 64'(busy), 0);
    @(negedge clk);
    check("E0_strobes", 64'(iw_cnt + dw_cnt - w0), 0);
    check("E0_reads", 64'(rd_cnt - r0), 0);

    // Reset mid-LOAD_D
    @(negedge clk);
    dmem_words = 8'd3;
    start = 1;
    w0 = dw_cnt;
    @(negedge clk);
    start = 0; s_valid = 1; s_data = 64'h11;
    @(negedge clk);
    s_data = 64'h22;
    #2;
    arst = 1;
    #1;
    check("F_wen", 64'(wen_ext_2), 0);
    check("F_sready", 64'(s_ready), 0);
    check("F_busy", 64'(busy), 0);
    check("F_addr", addr_ext_2, 0);
    check("F_wdata", wdata_ext_2, 0);
    check("F_mdata", m_data, 0);
    check("F_mvalid", 64'(m_valid), 0);
    @(negedge clk);
    arst = 0; s_valid = 0;
    check("F_writes", 64'(dw_cnt - w0), 1);
    @(negedge clk);
    dmem_words = 8'd1;
    start = 1;
    @(negedge clk);
    start = 0; s_valid = 1; s_data = 64'h33;
    #1;
    check("F_fresh_wen", 64'(wen_ext_2), 1);
    check("F_fresh_addr", addr_ext_2, 0);
    @(negedge clk);
    s_valid = 0; m_ready = 1;
    wait_done("F_done", 20);
    check("F_mem0", dmem[0], 64'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
